// File: rtl/split_frame_length_if.sv
`default_nettype none
// ============================================================================
//  Module      : split_frame_length_if
//  Description : AXI4-Stream style beat interface (data, valid, ready, last)
//                with master/slave views for the frame-length splitter.
//  Revision    : 1.0  initial release
// ============================================================================
interface split_frame_length_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   // Source side of a stream
   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   // Sink side of a stream
   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface
`default_nettype wire

// File: rtl/split_frame_length.sv
`default_nettype none
// ============================================================================
//  Module      : split_frame_length
//  Description : Splits [frame length header][frame] on one stream into a
//                header-only stream and a frame-only stream. Zero-latency
//                routing selected by registered state; also captures the
//                header value and checks the frame beat count against it.
//  Revision    : 1.0  initial release
// ============================================================================
module split_frame_length #(
   parameter int DATA_WIDTH         = 8,
   parameter int FRAME_LENGTH_WIDTH = 16,
   parameter int BEAT_COUNTER_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   split_frame_length_if.slave           s_axis,
   split_frame_length_if.master          m_axis_frame_length,
   split_frame_length_if.master          m_axis,
   output logic [FRAME_LENGTH_WIDTH-1:0] frame_length,
   output logic                          header_error,
   output logic                          length_error
);

   // Number of header beats and derived widths
   localparam int HB  = FRAME_LENGTH_WIDTH / DATA_WIDTH;
   localparam int HCW = (HB > 1) ? $clog2(HB) : 1;
   localparam int BPB = DATA_WIDTH / 8;
   // Comparison width wide enough for both the counter+1 and the rounded length
   localparam int CW  = ((BEAT_COUNTER_WIDTH > FRAME_LENGTH_WIDTH) ?
                         BEAT_COUNTER_WIDTH : FRAME_LENGTH_WIDTH) + 1;

   localparam logic [HCW-1:0]                HDR_LAST = HCW'(HB - 1);
   localparam logic [BEAT_COUNTER_WIDTH-1:0] BEAT_MAX = '1;

   localparam logic [0:0] ST_HEADER = 1'b0;
   localparam logic [0:0] ST_FRAME  = 1'b1;

   logic [0:0]                    state_q,        state_d;
   logic [HCW-1:0]                hdr_cnt_q,      hdr_cnt_d;
   logic [BEAT_COUNTER_WIDTH-1:0] beat_cnt_q,     beat_cnt_d;
   logic [FRAME_LENGTH_WIDTH-1:0] hdr_shadow_q,   hdr_shadow_d;
   logic [FRAME_LENGTH_WIDTH-1:0] frame_length_q, frame_length_d;
   logic                          header_error_q, header_error_d;
   logic                          length_error_q, length_error_d;

   logic          hs_hdr;
   logic          hs_frm;
   logic [CW-1:0] expected_beats;
   logic [CW-1:0] beat_cnt_next;
   logic          beat_sat;

   // Handshakes on whichever output the current state selects
   assign hs_hdr = rstn && (state_q == ST_HEADER) && s_axis.tvalid
                   && m_axis_frame_length.tready;
   assign hs_frm = rstn && (state_q == ST_FRAME) && s_axis.tvalid
                   && m_axis.tready;

   // Header is a byte count; a partially filled last beat still counts as a beat
   assign expected_beats = (CW'(frame_length_q) + CW'(BPB - 1)) / CW'(BPB);
   assign beat_cnt_next  = CW'(beat_cnt_q) + CW'(1);
   assign beat_sat       = (beat_cnt_q == BEAT_MAX);

   // State register: all flops, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= ST_HEADER;
         hdr_cnt_q      <= '0;
         beat_cnt_q     <= '0;
         hdr_shadow_q   <= '0;
         frame_length_q <= '0;
         header_error_q <= 1'b0;
         length_error_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         hdr_cnt_q      <= hdr_cnt_d;
         beat_cnt_q     <= beat_cnt_d;
         hdr_shadow_q   <= hdr_shadow_d;
         frame_length_q <= frame_length_d;
         header_error_q <= header_error_d;
         length_error_q <= length_error_d;
      end
   end

   // Next-state: header assembly, frame beat counting and error detection
   always_comb begin
      state_d        = state_q;
      hdr_cnt_d      = hdr_cnt_q;
      beat_cnt_d     = beat_cnt_q;
      hdr_shadow_d   = hdr_shadow_q;
      frame_length_d = frame_length_q;
      header_error_d = 1'b0;
      length_error_d = 1'b0;
      case (state_q)
         ST_HEADER: begin
            if (hs_hdr) begin
               hdr_shadow_d[hdr_cnt_q*DATA_WIDTH +: DATA_WIDTH] = s_axis.tdata;
               if (s_axis.tlast) begin
                  // Truncated header: drop it and resynchronise on the next beat
                  header_error_d = 1'b1;
                  hdr_cnt_d      = '0;
               end else if (hdr_cnt_q == HDR_LAST) begin
                  frame_length_d = hdr_shadow_d;
                  hdr_cnt_d      = '0;
                  beat_cnt_d     = '0;
                  state_d        = ST_FRAME;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            if (hs_frm) begin
               if (!beat_sat) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
               if (s_axis.tlast) begin
                  // A saturated counter can no longer prove the count matched
                  length_error_d = beat_sat || (beat_cnt_next != expected_beats);
                  state_d        = ST_HEADER;
                  hdr_cnt_d      = '0;
               end
            end
         end
      endcase
   end

   // Output routing: pass-through steered by state, everything gated in reset
   always_comb begin
      m_axis_frame_length.tdata  = s_axis.tdata;
      m_axis_frame_length.tlast  = (hdr_cnt_q == HDR_LAST) || s_axis.tlast;
      m_axis_frame_length.tvalid = 1'b0;
      m_axis.tdata               = s_axis.tdata;
      m_axis.tlast               = s_axis.tlast;
      m_axis.tvalid              = 1'b0;
      s_axis.tready              = 1'b0;
      if (rstn) begin
         if (state_q == ST_HEADER) begin
            m_axis_frame_length.tvalid = s_axis.tvalid;
            s_axis.tready              = m_axis_frame_length.tready;
         end else begin
            m_axis.tvalid = s_axis.tvalid;
            s_axis.tready = m_axis.tready;
         end
      end
   end

   assign frame_length = frame_length_q;
   assign header_error = header_error_q;
   assign length_error = length_error_q;

endmodule
`default_nettype wire

// File: tb/tb_split_frame_length.sv
`default_nettype none
// ============================================================================
//  Module      : tb_split_frame_length
//  Description : Randomised self-checking bench for split_frame_length.
//                Packets are built at packet level; the expected header
//                stream, frame stream, error pulses and captured length are
//                derived from the packet contents alone.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_split_frame_length;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // 8-bit instance
   split_frame_length_if #(.DATA_WIDTH(8)) s_if  ();
   split_frame_length_if #(.DATA_WIDTH(8)) fl_if ();
   split_frame_length_if #(.DATA_WIDTH(8)) m_if  ();
   logic [15:0] frame_length;
   logic        header_error, length_error;

   split_frame_length #(
      .DATA_WIDTH(8), .FRAME_LENGTH_WIDTH(16), .BEAT_COUNTER_WIDTH(16)
   ) u_dut (
      .clk                 (clk),
      .rstn                (rstn),
      .s_axis              (s_if),
      .m_axis_frame_length (fl_if),
      .m_axis              (m_if),
      .frame_length        (frame_length),
      .header_error        (header_error),
      .length_error        (length_error)
   );

   // 16-bit instance (single header beat)
   split_frame_length_if #(.DATA_WIDTH(16)) s2_if  ();
   split_frame_length_if #(.DATA_WIDTH(16)) fl2_if ();
   split_frame_length_if #(.DATA_WIDTH(16)) m2_if  ();
   logic [15:0] frame_length2;
   logic        header_error2, length_error2;

   split_frame_length #(
      .DATA_WIDTH(16), .FRAME_LENGTH_WIDTH(16), .BEAT_COUNTER_WIDTH(16)
   ) u_dut2 (
      .clk                 (clk),
      .rstn                (rstn),
      .s_axis              (s2_if),
      .m_axis_frame_length (fl2_if),
      .m_axis              (m2_if),
      .frame_length        (frame_length2),
      .header_error        (header_error2),
      .length_error        (length_error2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int          mode      = 0;   // 0: readies high, 1: scripted pattern, 2: random
   int          start_cyc = 0;
   logic [15:0] model_fl  = '0;  // expected captured length
   bit          exp_herr  = 0;   // expected error pulses at the next sample
   bit          exp_lerr  = 0;

   logic [8:0] exp_fl_q[$];
   logic [8:0] exp_m_q[$];
   logic [8:0] got_fl_q[$];
   logic [8:0] got_m_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock of stimulus plus sampling half a cycle away from the edge
   task automatic drive_cycle(input logic v, input logic [7:0] d, input logic l,
                              input bit sel_hdr, output bit hs);
      int rel;
      @(negedge clk);
      rel = cyc - start_cyc;
      case (mode)
         0: begin fl_if.tready = 1'b1; m_if.tready = 1'b1; end
         1: begin
            fl_if.tready = (rel >= 20);
            m_if.tready  = (((rel / 50) % 2) == 0);
         end
         default: begin
            fl_if.tready = ($urandom_range(0, 3) != 0);
            m_if.tready  = ($urandom_range(0, 3) != 0);
         end
      endcase
      s_if.tvalid = v;
      s_if.tdata  = d;
      s_if.tlast  = l;
      #1;
      check("header_error", header_error, exp_herr);
      check("length_error", length_error, exp_lerr);
      exp_herr = 0;
      exp_lerr = 0;
      check("s_tready_mirror", s_if.tready, sel_hdr ? fl_if.tready : m_if.tready);
      check("tvalid_route", {fl_if.tvalid, m_if.tvalid}, sel_hdr ? {v, 1'b0} : {1'b0, v});
      if (fl_if.tvalid && fl_if.tready) got_fl_q.push_back({fl_if.tlast, fl_if.tdata});
      if (m_if.tvalid && m_if.tready)   got_m_q.push_back({m_if.tlast, m_if.tdata});
      hs = v && s_if.tready;
      @(posedge clk);
   endtask

   // Two-cycle synchronous reset with everything upstream also restarting
   task automatic do_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rstn = 1'b0;
         s_if.tvalid = 1'b1;
         fl_if.tready = 1'b1;
         m_if.tready  = 1'b1;
         #1;
         check("reset_gating", {s_if.tready, fl_if.tvalid, m_if.tvalid}, 3'b000);
         @(posedge clk);
      end
      @(negedge clk);
      rstn = 1'b1;
      s_if.tvalid = 1'b0;
      #1;
      check("reset_frame_length", frame_length, 16'h0);
      check("reset_errors", {header_error, length_error}, 2'b00);
      @(posedge clk);
      model_fl = '0;
      exp_herr = 0;
      exp_lerr = 0;
      exp_fl_q.delete(); exp_m_q.delete(); got_fl_q.delete(); got_m_q.delete();
   endtask

   // Sends n_hdr header beats and n_frm frame bytes; herr sends a header cut
   // short by tlast instead. rst_at >= 0 resets before that beat index.
   task automatic send_pkt(input int n_hdr, input int n_frm, input logic [15:0] hdr,
                           input bit herr, input int rst_at);
      logic [7:0] pd[$];
      logic       pl[$];
      int         total;
      int         guard;
      bit         hs;
      logic       v;
      for (int i = 0; i < n_hdr; i++) begin
         pd.push_back(hdr[8*i +: 8]);
         pl.push_back(herr && (i == n_hdr - 1));
         exp_fl_q.push_back({(i == n_hdr - 1), hdr[8*i +: 8]});
      end
      if (!herr) begin
         for (int i = 0; i < n_frm; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            pd.push_back(b);
            pl.push_back(i == n_frm - 1);
            exp_m_q.push_back({(i == n_frm - 1), b});
         end
      end
      total = pd.size();
      for (int i = 0; i < total; i++) begin
         if (i == rst_at) begin
            do_reset();
            return;
         end
         guard = 0;
         do begin
            v = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_cycle(v, pd[i], pl[i], (i < n_hdr), hs);
            guard++;
         end while (!hs && guard < 1000);
         if (!hs) begin
            check("handshake_timeout", 0, 1);
            break;
         end
      end
      exp_herr = herr;
      exp_lerr = !herr && (n_frm != int'(hdr));
      if (!herr) model_fl = hdr;
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, hs);
      check("fl_beat_count", got_fl_q.size(), exp_fl_q.size());
      check("m_beat_count", got_m_q.size(), exp_m_q.size());
      foreach (exp_fl_q[k]) if (k < got_fl_q.size()) check("fl_beat", got_fl_q[k], exp_fl_q[k]);
      foreach (exp_m_q[k])  if (k < got_m_q.size())  check("m_beat", got_m_q[k], exp_m_q[k]);
      check("frame_length", frame_length, model_fl);
      exp_fl_q.delete(); exp_m_q.delete(); got_fl_q.delete(); got_m_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          hs;
      logic [15:0] d2;
      s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0;
      fl_if.tready = 0; m_if.tready = 0;
      s2_if.tvalid = 0; s2_if.tdata = '0; s2_if.tlast = 0;
      fl2_if.tready = 1; m2_if.tready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      fl_if.tready = 1; m_if.tready = 1;
      #1;
      check("reset_state_frame_length", frame_length, 16'h0);
      check("reset_state_errors", {header_error, length_error}, 2'b00);
      check("reset_state_valids", {fl_if.tvalid, m_if.tvalid}, 2'b00);
      @(posedge clk);

      // Nominal 1518-byte frame, readies high
      mode = 0;
      send_pkt(2, 1518, 16'h05EE, 0, -1);
      // Same with scripted back-pressure
      mode = 1; start_cyc = cyc;
      send_pkt(2, 1518, 16'h05EE, 0, -1);
      mode = 0;
      // Short frame then a correct one
      send_pkt(2, 60, 16'h0040, 0, -1);
      send_pkt(2, 64, 16'h0040, 0, -1);
      // Header cut by tlast; length register must keep 64
      send_pkt(1, 0, 16'h0012, 1, -1);
      send_pkt(2, 5, 16'h0005, 0, -1);
      // Zero-length header always flags the frame
      send_pkt(2, 3, 16'h0000, 0, -1);
      // Reset at frame byte 700, then a fresh frame
      send_pkt(2, 1518, 16'h05EE, 0, 2 + 699);
      send_pkt(2, 1518, 16'h05EE, 0, -1);

      // Random traffic with random back-pressure and gaps
      mode = 2;
      for (int p = 0; p < 40; p++) begin
         int sel, n;
         sel = $urandom_range(0, 9);
         n   = $urandom_range(1, 40);
         if (sel == 0)      send_pkt($urandom_range(1, 2), 0, 16'($urandom), 1, -1);
         else if (sel <= 2) send_pkt(2, n, 16'($urandom_range(0, 45)), 0, -1);
         else               send_pkt(2, n, 16'(n), 0, -1);
      end
      mode = 0;

      // 16-bit datapath: one header beat 0x05EE, 759 frame beats
      for (int i = 0; i <= 759; i++) begin
         @(negedge clk);
         d2 = (i == 0) ? 16'h05EE : 16'($urandom);
         s2_if.tvalid = 1'b1;
         s2_if.tdata  = d2;
         s2_if.tlast  = (i == 759);
         #1;
         if (i == 0)
            check("w16_header", {fl2_if.tvalid, fl2_if.tlast, fl2_if.tdata, m2_if.tvalid},
                  {1'b1, 1'b1, 16'h05EE, 1'b0});
         else
            check("w16_beat", {m2_if.tvalid, m2_if.tlast, m2_if.tdata, fl2_if.tvalid},
                  {1'b1, (i == 759), d2, 1'b0});
         check("w16_tready", s2_if.tready, 1'b1);
         @(posedge clk);
      end
      @(negedge clk);
      s2_if.tvalid = 1'b0;
      #1;
      check("w16_errors", {header_error2, length_error2}, 2'b00);
      check("w16_frame_length", frame_length2, 16'h05EE);
      @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/split_frame_length.md
Name: split_frame_length

Overview:
- Inverse of the frame-length merge stage: takes one AXI4-Stream carrying [frame length header][Ethernet frame] and splits it into two streams, a frame-length-only stream and a frame-only stream.
- Used at the egress of internal buffers, where the header must be removed before the MAC and the length must go to the scheduler/ATS logic.
- Also captures the header as a parallel value and checks the received beat count against it.

Parameters:
- DATA_WIDTH, 8, beat width in bits; must be a multiple of 8.
- FRAME_LENGTH_WIDTH, 16, header width in bits; must be a multiple of DATA_WIDTH. HB = FRAME_LENGTH_WIDTH/DATA_WIDTH header beats.
- BEAT_COUNTER_WIDTH, 16, width of the internal frame beat counter.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  input, header followed by frame
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  last frame beat
- m_axis_frame_length_tdata  out  DATA_WIDTH  header beats, LSB-first
- m_axis_frame_length_tvalid  out  1
- m_axis_frame_length_tready  in  1
- m_axis_frame_length_tlast  out  1  asserted on the final header beat
- m_axis_tdata  out  DATA_WIDTH  frame beats
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- frame_length  out  FRAME_LENGTH_WIDTH  last complete header captured, byte count
- header_error  out  1  one-cycle pulse: s_axis_tlast seen during the header
- length_error  out  1  one-cycle pulse: beat count disagrees with the header

Behaviour:
- Reset (rstn low at posedge clk):
  - state=HEADER; hdr_cnt=0; beat_cnt=0; frame_length=0; header_error=0; length_error=0.
  - While rstn=0, s_axis_tready, m_axis_tvalid and m_axis_frame_length_tvalid are forced 0.
- Datapath: zero latency, combinational routing selected by registered state. There is no internal buffering.
- State HEADER:
  - m_axis_frame_length_tvalid=s_axis_tvalid; s_axis_tready=m_axis_frame_length_tready; m_axis_frame_length_tdata=s_axis_tdata.
  - m_axis_frame_length_tlast=(hdr_cnt==HB-1) | s_axis_tlast.
  - m_axis_tvalid=0.
  - On each handshake, s_axis_tdata is written into header shadow bits [hdr_cnt*DATA_WIDTH +: DATA_WIDTH], LSB-first.
  - Handshake with hdr_cnt==HB-1 and s_axis_tlast=0: frame_length <= assembled header; hdr_cnt<=0; beat_cnt<=0; state<=FRAME.
  - Handshake with s_axis_tlast=1 (any hdr_cnt): header_error pulses the next cycle; hdr_cnt<=0; state stays HEADER; frame_length is unchanged.
  - Otherwise hdr_cnt increments.
- State FRAME:
  - m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready; tdata and tlast pass through.
  - m_axis_frame_length_tvalid=0.
  - On each handshake beat_cnt increments, saturating at all-ones.
  - On a handshake with s_axis_tlast=1:
    - expected = ceil(frame_length/(DATA_WIDTH/8)).
    - length_error pulses the next cycle if (beat_cnt+1) != expected, or if beat_cnt was saturated.
    - state<=HEADER; hdr_cnt<=0.
- tdata/tlast on an idle output (tvalid=0) are don't-care. Input is never consumed without a handshake on the selected output.
- Back-pressure:
  - tvalid must not depend on tready.
  - Stalls on the selected output hold s_axis_tready low with no state change.
  - The non-selected output's tready is ignored.
- HB=1 case: every header beat is also the frame_length tlast.
- Zero-length header value: expected=0, so any frame produces length_error.
- Reset mid-frame:
  - Returns to HEADER immediately; partial output frames are not terminated.
  - Upstream must be reset together with this block.
- Error pulses are exactly one cycle wide and are independent, one per event. header_error and length_error never assert in the same cycle.

Test Plan:
- DW=8, FLW=16, input 0xEE,0x05 then 1518 bytes, last with tlast, both readies=1:
  - frame_length stream gets 0xEE then 0x05 (tlast on 0x05).
  - m_axis gets the 1518 bytes, tlast on byte 1518.
  - frame_length=1518; no errors.
- Same stimulus with m_axis_tready toggling every 50 cycles and m_axis_frame_length_tready low for the first 20 cycles: identical output byte sequences; no beat lost or duplicated; s_axis_tready mirrors the selected tready.
- Header 0x40,0x00 (64), frame sent as 60 bytes: length_error pulses one cycle after the tlast beat. The next frame 0x40,0x00 + 64 bytes passes with no error.
- Header beat 0x12 with s_axis_tlast=1:
  - header_error pulses; frame_length output gets 0x12 with tlast.
  - frame_length register unchanged; the next beats are parsed as a new header.
- rstn low for 2 cycles at byte 700 of a 1518-byte frame:
  - all tvalid/tready are 0 during reset; error outputs and frame_length are 0 after reset.
  - A fresh frame is then split correctly.
- DW=16, FLW=16, header 0x05EE, 759 beats: a single header beat with tlast; no length_error.
